// File: rtl/payload_distributor.sv
// Drains one rx input FIFO and scatters each {EOS, DEST, LEN} header plus its
// LEN payload words into one of TOTAL_OUTPUT_FIFOS destination FIFOs.
module payload_distributor #(
    parameter int TOTAL_OUTPUT_FIFOS = 4,
    parameter int DATA_W             = 32,
    parameter int LEN_W              = 16,
    parameter int RDLATENCY          = 2,
    localparam int SEL_W             = $clog2(TOTAL_OUTPUT_FIFOS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W-1:0]             in_q,
    input  logic                          in_empty,
    output logic                          in_rdreq,
    output logic [DATA_W-1:0]             out_d,
    output logic [TOTAL_OUTPUT_FIFOS-1:0] out_wrreq,
    input  logic [TOTAL_OUTPUT_FIFOS-1:0] out_half_full,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_REQ  = 3'd1,
        HDR_WAIT = 3'd2,
        PAYLOAD  = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt;
    logic [RDLATENCY-1:0]  vld_pipe_r;
    logic [RDLATENCY-1:0]  hdr_pipe_r;
    logic [LEN_W-1:0]      len_r;
    logic [LEN_W-1:0]      req_cnt_r;
    logic [SEL_W-1:0]      dest_r;
    logic                  dest_ok_r;
    logic                  eos_r;

    logic [LEN_W-1:0]      hdr_len_s;
    logic [SEL_W-1:0]      hdr_dest_s;
    logic                  hdr_eos_s;
    logic                  hdr_dest_ok_s;
    logic                  hdr_valid_s;
    logic                  pay_valid_s;
    logic                  dest_hf_s;
    logic                  rdreq_s;
    logic                  rd_hdr_s;
    logic                  latch_s;
    logic                  eos_set_s;
    logic                  parse_err_s;

    assign hdr_len_s     = in_q[LEN_W-1:0];
    assign hdr_dest_s    = in_q[LEN_W+SEL_W-1:LEN_W];
    assign hdr_eos_s     = in_q[DATA_W-1];
    assign hdr_dest_ok_s = ({1'b0, hdr_dest_s} < (SEL_W+1)'(TOTAL_OUTPUT_FIFOS));
    // The top of the read-valid pipe marks the word currently presented on in_q.
    assign hdr_valid_s   = vld_pipe_r[RDLATENCY-1] & hdr_pipe_r[RDLATENCY-1];
    assign pay_valid_s   = vld_pipe_r[RDLATENCY-1] & ~hdr_pipe_r[RDLATENCY-1];
    // A discarded packet has no real destination, so it never waits on backpressure.
    assign dest_hf_s     = dest_ok_r ? out_half_full[dest_r] : 1'b0;
    assign in_rdreq      = rdreq_s;

    // Next-state and read-request decode.
    always_comb begin
        state_nxt   = state_r;
        rdreq_s     = 1'b0;
        rd_hdr_s    = 1'b0;
        latch_s     = 1'b0;
        eos_set_s   = 1'b0;
        parse_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = HDR_REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HDR_REQ: begin
                if (!in_empty) begin
                    rdreq_s   = 1'b1;
                    rd_hdr_s  = 1'b1;
                    state_nxt = HDR_WAIT;
                end else begin
                    state_nxt = HDR_REQ;
                end
            end
            HDR_WAIT: begin
                if (!hdr_valid_s) begin
                    state_nxt = HDR_WAIT;
                end else if (hdr_eos_s) begin
                    eos_set_s = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    parse_err_s = ~hdr_dest_ok_s;
                    if (hdr_len_s == {LEN_W{1'b0}}) begin
                        state_nxt = HDR_REQ;
                    end else begin
                        latch_s   = 1'b1;
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!in_empty && (req_cnt_r < len_r) && !dest_hf_s) begin
                    rdreq_s = 1'b1;
                    if (req_cnt_r == (len_r - LEN_W'(1))) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end else begin
                    state_nxt = PAYLOAD;
                end
            end
            DRAIN: begin
                if (vld_pipe_r == {RDLATENCY{1'b0}}) begin
                    state_nxt = eos_r ? IDLE : HDR_REQ;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, read tracking, header latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            vld_pipe_r <= '0;
            hdr_pipe_r <= '0;
            len_r      <= '0;
            req_cnt_r  <= '0;
            dest_r     <= '0;
            dest_ok_r  <= 1'b0;
            eos_r      <= 1'b0;
            out_d      <= '0;
            out_wrreq  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            vld_pipe_r <= (vld_pipe_r << 1) | RDLATENCY'(rdreq_s);
            hdr_pipe_r <= (hdr_pipe_r << 1) | RDLATENCY'(rd_hdr_s);
            if (latch_s) begin
                dest_r    <= hdr_dest_s;
                len_r     <= hdr_len_s;
                dest_ok_r <= hdr_dest_ok_s;
                req_cnt_r <= '0;
            end else if ((state_r == PAYLOAD) && rdreq_s) begin
                req_cnt_r <= req_cnt_r + LEN_W'(1);
            end
            if (eos_set_s) begin
                eos_r <= 1'b1;
            end else if (state_r == IDLE) begin
                eos_r <= 1'b0;
            end
            out_wrreq <= '0;
            if (pay_valid_s && dest_ok_r) begin
                out_d     <= in_q;
                out_wrreq <= TOTAL_OUTPUT_FIFOS'(1) << dest_r;
            end
            busy <= (state_nxt != IDLE);
            done <= (state_r == DRAIN) && (state_nxt == IDLE);
            err  <= parse_err_s;
        end
    end

endmodule
